// File: rtl/pulse_count_uart.sv
// pulse_count_uart: counts rising edges of an asynchronous pulse input over a
// fixed gate window, latches the count and reports it as an 8N1 UART frame
// (sync byte 0xA5, then the count MSB byte first). report_pulse is high while
// a frame is on the wire; overrun flags window results that found the
// transmitter busy.
// Optional feature macro: REPORT_CKSUM_EN appends an XOR checksum of the count
// bytes to every frame.
module pulse_count_uart #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned GATE_CYCLES  = 40000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             uart_tx,
  output logic             report_pulse,
  output logic             overrun,
  output logic [CNT_W-1:0] count_q
);

  localparam int unsigned NB = (CNT_W + 7) / 8;
`ifdef REPORT_CKSUM_EN
  localparam int unsigned NBYTES = NB + 2;
`else
  localparam int unsigned NBYTES = NB + 1;
`endif
  localparam int unsigned FW = NBYTES * 8;
  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(NBYTES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync_d;
  logic              w_edge;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  w_sum;
  logic [GW-1:0]     r_gate_cnt;
  logic              w_latch;
  logic [NB*8-1:0]   w_cnt_ext;
  logic [FW-1:0]     w_frame;
  logic [FW-1:0]     r_frame;
  logic [7:0]        w_cur_byte;
  logic [CW-1:0]     r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [BW-1:0]     r_byte_idx;
  logic              w_bit_end;
`ifdef REPORT_CKSUM_EN
  logic [7:0]        w_cksum;
`endif

  // two-stage synchronizer on the pad plus a delayed copy for edge detection
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= pulse_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // edge detect, window terminal cycle and the saturated count including this cycle's edge
  always_comb begin
    w_edge  = r_sync2 & ~r_sync_d;
    w_latch = enable && (r_gate_cnt == GATE_LAST);
    w_sum   = r_edge_cnt;
    if (w_edge && (r_edge_cnt != '1)) w_sum = r_edge_cnt + 1'b1;
  end

  // frame image built from the value being latched: sync, count bytes, optional checksum
  always_comb begin
    w_cnt_ext              = '0;
    w_cnt_ext[CNT_W-1:0]   = w_sum;
    w_frame                = '0;
    w_frame[FW-1 -: 8]     = 8'hA5;
    w_frame[FW-9 -: NB*8]  = w_cnt_ext;
`ifdef REPORT_CKSUM_EN
    w_cksum = '0;
    for (int unsigned i = 0; i < NB; i++) w_cksum ^= w_cnt_ext[i*8 +: 8];
    w_frame[7:0] = w_cksum;
`endif
  end

  // gate window, edge counting, result latch and sticky overrun; all held clear while disabled
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      count_q    <= '0;
      overrun    <= 1'b0;
    end else if (!enable) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      overrun    <= 1'b0;
    end else if (w_latch) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      count_q    <= w_sum;
      if (r_state != IDLE) overrun <= 1'b1;
    end else begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
      r_edge_cnt <= w_sum;
    end
  end

  // transmitter next-state logic
  always_comb begin
    w_bit_end = (r_clk_cnt == BIT_LAST);
    w_next    = r_state;
    case (r_state)
      IDLE:    if (w_latch) w_next = START;
      START:   if (w_bit_end) w_next = DATA;
      DATA:    if (w_bit_end && (r_bit_idx == 3'd7)) w_next = STOP;
      STOP:    if (w_bit_end) w_next = (r_byte_idx == BYTE_LAST) ? IDLE : START;
      default: w_next = IDLE;
    endcase
  end

  // transmitter state, bit timing and frame shift register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_frame    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_clk_cnt  <= '0;
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
        if (w_latch) r_frame <= w_frame;
      end else begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
        // bit index wraps back to 0 after bit 7, ready for the next byte
        if ((r_state == DATA) && w_bit_end) r_bit_idx <= r_bit_idx + 1'b1;
        if ((r_state == STOP) && w_bit_end) begin
          r_byte_idx <= r_byte_idx + 1'b1;
          r_frame    <= r_frame << 8;
        end
      end
    end
  end

  // line driver decoded from registered state so reset forces the idle level at once
  always_comb begin
    w_cur_byte   = r_frame[FW-1 -: 8];
    report_pulse = (r_state != IDLE);
    case (r_state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = w_cur_byte[r_bit_idx];
      default: uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pulse_count_uart.sv
`timescale 1ns/1ps
module tb_pulse_count_uart;

  localparam int CPB = 4;

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  logic en_a = 1'b0, en_o = 1'b0, en_s = 1'b0;
  logic p_a = 1'b0, p_s = 1'b0;
  logic tx_a, rp_a, ov_a;
  logic tx_o, rp_o, ov_o;
  logic tx_s, rp_s, ov_s;
  logic [15:0] cq_a, cq_o;
  logic [3:0]  cq_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode_a = 0;
  int mode_s = 0;
  int o_start = 0;
  bit hist_a [0:65535];
  bit hist_s [0:65535];
  byte unsigned exp_b [0:7];
  int exp_n = 0;

  pulse_count_uart #(.CLKS_PER_BIT(CPB), .GATE_CYCLES(200), .CNT_W(16)) u_dut (
    .clock(clock), .resetb(resetb), .enable(en_a), .pulse_in(p_a),
    .uart_tx(tx_a), .report_pulse(rp_a), .overrun(ov_a), .count_q(cq_a));

  pulse_count_uart #(.CLKS_PER_BIT(CPB), .GATE_CYCLES(100), .CNT_W(16)) u_ovr (
    .clock(clock), .resetb(resetb), .enable(en_o), .pulse_in(p_a),
    .uart_tx(tx_o), .report_pulse(rp_o), .overrun(ov_o), .count_q(cq_o));

  pulse_count_uart #(.CLKS_PER_BIT(CPB), .GATE_CYCLES(200), .CNT_W(4)) u_sat (
    .clock(clock), .resetb(resetb), .enable(en_s), .pulse_in(p_s),
    .uart_tx(tx_s), .report_pulse(rp_s), .overrun(ov_s), .count_q(cq_s));

  always #5 clock = ~clock;

  // pad history: hist[n] is the pad level seen at posedge number n
  always @(posedge clock) begin
    hist_a[cyc] = p_a;
    hist_s[cyc] = p_s;
    cyc = cyc + 1;
  end

  initial begin : gen_a
    int ph;
    int hold;
    ph = 0;
    hold = 0;
    forever begin
      @(posedge clock);
      #1;
      case (mode_a)
        1: begin p_a = (ph < 5); ph = (ph == 9) ? 0 : ph + 1; end
        2: begin
          if (hold == 0) begin p_a = ~p_a; hold = $urandom_range(0, 5); end
          else hold--;
        end
        default: p_a = 1'b0;
      endcase
    end
  end

  initial begin : gen_s
    int ph;
    ph = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mode_s == 1) begin p_s = (ph < 2); ph = (ph == 3) ? 0 : ph + 1; end
      else p_s = 1'b0;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: a pad rise between samples m-1 and m is counted at posedge m+2.
  // Window j of a run enabled with first counting posedge 'start' spans
  // posedges start+(j-1)*g .. start+j*g-1; the result saturates at 2^w-1.
  function automatic int model_count(input int src, input int start, input int g,
                                     input int j, input int w);
    int n;
    int mx;
    n = 0;
    mx = (1 << w) - 1;
    for (int p = start + (j-1)*g; p <= start + j*g - 1; p++) begin
      bit a;
      bit b;
      a = (src == 0) ? hist_a[p-3] : hist_s[p-3];
      b = (src == 0) ? hist_a[p-2] : hist_s[p-2];
      if (!a && b) n++;
    end
    return (n > mx) ? mx : n;
  endfunction

  task automatic set_expected(input int cnt, input int w);
    int nb;
    nb = (w + 7) / 8;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < nb; k++) exp_b[1+k] = 8'((cnt >> (8*(nb-1-k))) & 255);
    exp_n = 1 + nb;
`ifdef REPORT_CKSUM_EN
    begin
      byte unsigned ck;
      ck = 8'h00;
      for (int k = 0; k < nb; k++) ck ^= exp_b[1+k];
      exp_b[exp_n] = ck;
      exp_n++;
    end
`endif
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      0: return tx_a;
      1: return tx_o;
      default: return tx_s;
    endcase
  endfunction

  function automatic logic rp_of(input int sel);
    case (sel)
      0: return rp_a;
      1: return rp_o;
      default: return rp_s;
    endcase
  endfunction

  // Decode the frame that starts after posedge L and measure report_pulse width.
  task automatic check_frame(input int sel, input int L, input string tag, input int drop_at);
    int t_exp;
    int hi;
    int k;
    byte unsigned got;
    logic bits [0:79];
    t_exp = exp_n * 10 * CPB;
    hi = 0;
    k = 0;
    while (cyc <= L) @(negedge clock);
    while (k < t_exp + 8) begin
      if (k == drop_at) en_o = 1'b0;
      if (rp_of(sel) !== 1'b1) break;
      hi++;
      if (((k % CPB) == CPB/2) && ((k / CPB) < exp_n*10)) bits[k/CPB] = tx_of(sel);
      k++;
      @(negedge clock);
    end
    total++;
    if (hi !== t_exp) begin
      bad++;
      $display("FAIL %s report_len got=%0d exp=%0d", tag, hi, t_exp);
    end
    for (int b = 0; b < exp_n; b++) begin
      got = 8'h00;
      for (int d = 0; d < 8; d++) got[d] = bits[b*10+1+d];
      total++;
      if (bits[b*10] !== 1'b0 || bits[b*10+9] !== 1'b1 || got !== exp_b[b]) begin
        bad++;
        $display("FAIL %s byte%0d got=%02h start=%b stop=%b exp=%02h start=0 stop=1",
                 tag, b, got, bits[b*10], bits[b*10+9], exp_b[b]);
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx_a); end
    total++; if (rp_a !== 1'b0) begin bad++; $display("FAIL rst_rp got=%b exp=0", rp_a); end
    total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b exp=0", ov_a); end
    total++; if (cq_a !== 16'h0000) begin bad++; $display("FAIL rst_cq got=%h exp=0000", cq_a); end
    total++;
    if ({tx_o, rp_o, ov_o, tx_s, rp_s, ov_s} !== 6'b100100 || cq_o !== 16'h0 || cq_s !== 4'h0) begin
      bad++;
      $display("FAIL rst_others got=%b%b%b%b%b%b/%h/%h exp=100100/0000/0", tx_o, rp_o, ov_o,
               tx_s, rp_s, ov_s, cq_o, cq_s);
    end
    resetb = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_windows(input string tag, input bit fixed20);
    int start;
    int L;
    int e;
    en_a = 1'b1;
    start = cyc;
    for (int j = 1; j <= 3; j++) begin
      L = start + j*200 - 1;
      while (cyc <= L) @(negedge clock);
      e = model_count(0, start, 200, j, 16);
      total++;
      if (cq_a !== 16'(e)) begin bad++; $display("FAIL %s count_w%0d got=%h exp=%h", tag, j, cq_a, e); end
      if (fixed20 && j >= 2) begin
        total++;
        if (cq_a !== 16'h0014) begin bad++; $display("FAIL %s steady_w%0d got=%h exp=0014", tag, j, cq_a); end
      end
      set_expected(e, 16);
      check_frame(0, L, tag, -1);
      total++;
      if (ov_a !== 1'b0) begin bad++; $display("FAIL %s overrun got=%b exp=0", tag, ov_a); end
    end
    en_a = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_steady();
    mode_a = 1;
    repeat (20) @(negedge clock);
    run_windows("steady", 1'b1);
  endtask

  task automatic test_random();
    mode_a = 2;
    repeat (20) @(negedge clock);
    run_windows("random", 1'b0);
  endtask

  task automatic test_overrun();
    int L1;
    int e;
    mode_a = 1;
    repeat (5) @(negedge clock);
    en_o = 1'b1;
    o_start = cyc;
    L1 = o_start + 99;
    while (cyc <= L1) @(negedge clock);
    e = model_count(0, o_start, 100, 1, 16);
    total++;
    if (cq_o !== 16'(e)) begin bad++; $display("FAIL ovr_w1 got=%h exp=%h", cq_o, e); end
    set_expected(e, 16);
    check_frame(1, L1, "ovr_frame1", -1);
    e = model_count(0, o_start, 100, 2, 16);
    total++;
    if (cq_o !== 16'(e) || cq_o !== 16'h000A) begin
      bad++; $display("FAIL ovr_w2 got=%h exp=%h (000a)", cq_o, e);
    end
    total++;
    if (ov_o !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", ov_o); end
    while (cyc <= o_start + 298) @(negedge clock);
    total++;
    if (rp_o !== 1'b0) begin bad++; $display("FAIL ovr_no_queue report got=%b exp=0", rp_o); end
  endtask

  task automatic test_enable();
    int L;
    int e;
    int n;
    int s2;
    L = o_start + 299;
    while (cyc <= L) @(negedge clock);
    e = model_count(0, o_start, 100, 3, 16);
    total++;
    if (cq_o !== 16'(e)) begin bad++; $display("FAIL en_w3 got=%h exp=%h", cq_o, e); end
    set_expected(e, 16);
    check_frame(1, L, "en_drop_frame", 30);
    total++;
    if (ov_o !== 1'b0) begin bad++; $display("FAIL en_ov_clear got=%b exp=0", ov_o); end
    n = 0;
    repeat (300) begin
      @(negedge clock);
      if (rp_o !== 1'b0) n++;
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL en_no_frames got=%0d exp=0", n); end
    en_o = 1'b1;
    s2 = cyc;
    L = s2 + 99;
    while (cyc <= L) @(negedge clock);
    e = model_count(0, s2, 100, 1, 16);
    total++;
    if (cq_o !== 16'(e)) begin bad++; $display("FAIL en_reenable got=%h exp=%h", cq_o, e); end
    set_expected(e, 16);
    check_frame(1, L, "en_reenable_frame", -1);
    en_o = 1'b0;
  endtask

  task automatic test_saturation();
    int start;
    int L;
    int e;
    mode_s = 1;
    repeat (10) @(negedge clock);
    en_s = 1'b1;
    start = cyc;
    L = start + 199;
    while (cyc <= L) @(negedge clock);
    e = model_count(1, start, 200, 1, 4);
    total++;
    if (cq_s !== 4'(e) || cq_s !== 4'hF) begin bad++; $display("FAIL sat_count got=%h exp=%h (f)", cq_s, e); end
    set_expected(e, 4);
    check_frame(2, L, "sat_frame", -1);
    en_s = 1'b0;
    mode_s = 0;
  endtask

  task automatic test_reset_mid();
    int start;
    int L;
    mode_a = 1;
    repeat (5) @(negedge clock);
    en_a = 1'b1;
    start = cyc;
    L = start + 199;
    // sync byte data bit 1 is a zero, so the line is low here
    while (cyc <= L + 2*CPB + 1) @(negedge clock);
    total++;
    if (tx_a !== 1'b0 || rp_a !== 1'b1) begin
      bad++; $display("FAIL mid_pre tx/rp got=%b%b exp=01", tx_a, rp_a);
    end
    resetb = 1'b0;
    #1;
    total++;
    if (tx_a !== 1'b1 || rp_a !== 1'b0 || cq_a !== 16'h0) begin
      bad++; $display("FAIL mid_reset tx/rp/cq got=%b%b/%h exp=10/0000", tx_a, rp_a, cq_a);
    end
    @(negedge clock);
    resetb = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if (rp_a !== 1'b0 || tx_a !== 1'b1) begin
      bad++; $display("FAIL mid_after tx/rp got=%b%b exp=10", tx_a, rp_a);
    end
    en_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_overrun();
    test_enable();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
